shift_sequencer: RTL and testbench

Sequencing controller for the 6-bit D-flip-flop shift register used in the flip-flop exercises. The block owns the register. On a start request it parallel-loads a word, applies a programmed number of shift or rotate steps in either direction, and signals completion with a handshake. It replaces hand-written clock/data stimulus sequences with a single start request, so benches and upper levels can drive serial data patterns deterministically.

---
 rtl/shift_sequencer_if.sv | 27 ++
 rtl/shift_sequencer.sv | 144 ++++++++++++++
 tb/tb_shift_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// Request/response bundle for the shift sequencer: operation request fields
// from the controlling side, register contents and handshake back.
interface shift_sequencer_if #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 3
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] load_val;
    logic [1:0]       mode;
    logic [CNT_W-1:0] count;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, load_val, mode, count, sin,
        input  q, sout, busy, done
    );

    modport slave (
        input  start, abort, load_val, mode, count, sin,
        output q, sout, busy, done
    );
endinterface

// File: rtl/shift_sequencer.sv
// Sequencing controller owning a WIDTH-bit shift register: parallel load on
// start, then a programmed number of shift/rotate steps ending in a done pulse.
module shift_sequencer #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 3
) (
    input  logic              clk,
    input  logic              clr,
    shift_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt_s;
    logic             sout_r;
    logic             sout_nxt_s;
    logic [1:0]       mode_r;
    logic [1:0]       mode_nxt_s;
    logic [CNT_W-1:0] rem_r;
    logic [CNT_W-1:0] rem_nxt_s;
    logic             busy_r;
    logic             busy_nxt_s;
    logic             done_r;
    logic             done_nxt_s;

    // One step of the register: returns {outgoing bit, new word}. mode[0]
    // selects direction (0 = left), mode[1] selects rotate over shift.
    function automatic logic [WIDTH:0] step_word(
        input logic [WIDTH-1:0] word,
        input logic [1:0]       md,
        input logic             sin_i
    );
        logic             out_b;
        logic             in_b;
        logic [WIDTH-1:0] nw;
        if (md[0] == 1'b0) begin
            out_b = word[WIDTH-1];
            in_b  = md[1] ? out_b : sin_i;
            nw    = {word[WIDTH-2:0], in_b};
        end else begin
            out_b = word[0];
            in_b  = md[1] ? out_b : sin_i;
            nw    = {in_b, word[WIDTH-1:1]};
        end
        return {out_b, nw};
    endfunction

    // State register with handshake outputs registered alongside it
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Next-state decode; abort wins over the final step
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt_s = (bus.count != {CNT_W{1'b0}}) ? ST_SHIFT : ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bus.abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (rem_r == CNT_W'(1)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Datapath and handshake next values; everything holds unless acted on
    always_comb begin
        q_nxt_s    = q_r;
        sout_nxt_s = sout_r;
        mode_nxt_s = mode_r;
        rem_nxt_s  = rem_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    q_nxt_s    = bus.load_val;
                    mode_nxt_s = bus.mode;
                    rem_nxt_s  = bus.count;
                end else begin
                    rem_nxt_s  = rem_r;
                end
            end
            ST_SHIFT: begin
                if (bus.abort) begin
                    rem_nxt_s = {CNT_W{1'b0}};
                end else begin
                    {sout_nxt_s, q_nxt_s} = step_word(q_r, mode_r, bus.sin);
                    rem_nxt_s = rem_r - CNT_W'(1);
                end
            end
            ST_DONE: rem_nxt_s = {CNT_W{1'b0}};
            default: rem_nxt_s = {CNT_W{1'b0}};
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE);
        done_nxt_s = (state_nxt_s == ST_DONE);
    end

    // Register contents, outgoing bit, latched mode and remaining-step counter
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q_r    <= {WIDTH{1'b1}};
            sout_r <= 1'b0;
            mode_r <= 2'b00;
            rem_r  <= {CNT_W{1'b0}};
        end else begin
            q_r    <= q_nxt_s;
            sout_r <= sout_nxt_s;
            mode_r <= mode_nxt_s;
            rem_r  <= rem_nxt_s;
        end
    end

    assign bus.q    = q_r;
    assign bus.sout = sout_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized bench for shift_sequencer: each operation's expected cycle trace
// is derived from an arithmetic model of the register (multiply/divide by 2).
module tb_shift_sequencer;

    logic clk = 1'b0;
    logic clr;
    int   n_cmp = 0;
    int   n_mis = 0;
    int   mq;
    int   msout;

    shift_sequencer_if #(.WIDTH(6), .CNT_W(3)) bus ();

    shift_sequencer #(.WIDTH(6), .CNT_W(3)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int bsy, input int dn);
        chk({tag, ".q"},    32'(bus.q),    32'(mq));
        chk({tag, ".sout"}, 32'(bus.sout), 32'(msout));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(bsy));
        chk({tag, ".done"}, 32'(bus.done), 32'(dn));
    endtask

    // stop_k: SHIFT cycle (1-based) in which abort or clr strikes, 0 = none.
    // sin_fix: constant serial input, or -1 for random bits.
    task automatic do_op(input int lv, input int md, input int cnt,
                         input int stop_k, input bit use_clr, input int sin_fix);
        logic [8:0] sins;
        int outb;
        int inb;
        bit ab;
        sins = 9'($urandom);
        if (sin_fix >= 0) sins = {9{sin_fix[0]}};
        bus.start    = 1'b1;
        bus.load_val = 6'(lv);
        bus.mode     = 2'(md);
        bus.count    = 3'(cnt);
        bus.abort    = 1'b0;
        bus.sin      = 1'($urandom);
        @(posedge clk);
        #1;
        bus.start    = 1'($urandom_range(0, 1));
        bus.load_val = 6'd0;
        bus.mode     = 2'($urandom);
        bus.count    = 3'($urandom);
        mq = lv;
        @(negedge clk);
        chk_all("load", 1, (cnt == 0) ? 1 : 0);
        if (cnt == 0) begin
            bus.start = 1'b0;
            @(negedge clk);
            chk_all("zero_end", 0, 0);
            return;
        end
        for (int j = 1; j <= cnt; j++) begin
            bus.sin   = sins[j];
            ab        = (!use_clr && j == stop_k);
            bus.abort = ab;
            bus.start = 1'($urandom_range(0, 1));
            if (use_clr && j == stop_k) begin
                bus.start = 1'b0;
                clr = 1'b1;
                #1;
                mq = 63;
                msout = 0;
                chk_all("clr_async", 0, 0);
                #1 clr = 1'b0;
                @(negedge clk);
                chk_all("clr_after", 0, 0);
                return;
            end
            @(negedge clk);
            if (ab) begin
                bus.abort = 1'b0;
                bus.start = 1'b0;
                chk_all("abort", 0, 0);
                return;
            end
            if (md % 2 == 0) begin
                outb = mq / 32;
                inb  = (md >= 2) ? outb : int'(sins[j]);
                mq   = (mq * 2) % 64 + inb;
            end else begin
                outb = mq % 2;
                inb  = (md >= 2) ? outb : int'(sins[j]);
                mq   = mq / 2 + inb * 32;
            end
            msout = outb;
            chk_all("step", 1, (j == cnt) ? 1 : 0);
        end
        bus.start = 1'b0;
        @(negedge clk);
        chk_all("end", 0, 0);
    endtask

    initial begin
        int cnt;
        int stop;
        bit uc;
        clr          = 1'b1;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.load_val = 6'd0;
        bus.mode     = 2'd0;
        bus.count    = 3'd0;
        bus.sin      = 1'b0;
        mq    = 63;
        msout = 0;
        #2;
        chk_all("reset", 0, 0);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        chk_all("idle", 0, 0);

        do_op(6'b101100, 0, 3, 0, 1'b0, 1);
        do_op(6'b000001, 3, 6, 0, 1'b0, -1);
        do_op(6'b010101, 0, 0, 0, 1'b0, -1);
        do_op(6'b111000, 1, 5, 3, 1'b0, 0);
        do_op(6'b110110, 2, 7, 4, 1'b1, -1);
        do_op(6'b100101, 1, 7, 0, 1'b0, -1);

        for (int i = 0; i < 60; i++) begin
            cnt  = $urandom_range(0, 7);
            stop = 0;
            uc   = 1'b0;
            if (cnt > 0 && $urandom_range(0, 3) == 0) begin
                stop = $urandom_range(1, cnt);
                uc   = ($urandom_range(0, 2) == 0);
            end
            do_op($urandom_range(0, 63), $urandom_range(0, 3), cnt, stop, uc, -1);
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                bus.sin = 1'($urandom);
                @(negedge clk);
                chk_all("hold", 0, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
